// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS core: drives every datapath select and
// write enable per phase, stalls on memory wait states and halts on faults.
module multicycle_control #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t           state_reg, state_next;
    logic [7:0]       wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] instr_count_reg;
    logic             illegal_op_reg, mem_timeout_reg;
    logic             in_wait_state, wait_expired;
    logic             retire, set_illegal, set_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= 8'd0;
            instr_count_reg <= '0;
            illegal_op_reg  <= 1'b0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (retire)
                instr_count_reg <= instr_count_reg + CNT_W'(1);
            if (set_illegal)
                illegal_op_reg <= 1'b1;
            if (set_timeout)
                mem_timeout_reg <= 1'b1;
        end
    end

    // Only the three memory-facing states accumulate wait cycles; every other
    // state (and any completed access) leaves the counter at zero for the next entry.
    assign in_wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                           (state_reg == S_MEMWR);
    assign wait_expired  = in_wait_state && !mem_ready &&
                           ((wait_cnt_reg + 8'd1) == MAX_WAIT_C);
    assign wait_cnt_next = (in_wait_state && !mem_ready) ? wait_cnt_reg + 8'd1 : 8'd0;

    always_comb begin
        state_next  = state_reg;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next  = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default: begin
                        state_next  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (wait_expired) begin
                    state_next  = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe stays up across the whole wait; the memory latches on mem_ready.
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (wait_expired) begin
                    state_next  = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
    end

    // Any return to FETCH from a post-decode state completes an instruction.
    assign retire = (state_next == S_FETCH) &&
                    (state_reg != S_IDLE) && (state_reg != S_FETCH);

    assign state       = state_reg;
    assign halted      = (state_reg == S_HALT);
    assign illegal_op  = illegal_op_reg;
    assign mem_timeout = mem_timeout_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectations are queued as the
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_multicycle_control;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic             mem_ready = 1'b1;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic             halted, illegal_op, mem_timeout;
    logic [CNT_W-1:0] instr_count;

    multicycle_control #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .halted(halted), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic [15:0]      ctrl;
        logic             hlt;
        logic             ill;
        logic             tmo;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    string            tag_q[$];
    int               total = 0;
    int               bad = 0;
    logic             exp_ill = 1'b0;
    logic             exp_to = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [15:0]      obs_ctrl;

    assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [15:0] ctrl_of(input logic [3:0] st, input logic rdy);
        case (st)
            4'd1:    ctrl_of = {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 4'b0000, 2'b01, 2'b00, 2'b00};
            4'd2:    ctrl_of = {10'b0000000000, 2'b11, 2'b00, 2'b00};
            4'd3:    ctrl_of = {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00};
            4'd4:    ctrl_of = {2'b00, 1'b1, 1'b1, 6'b000000, 6'b000000};
            4'd5:    ctrl_of = {6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
            4'd6:    ctrl_of = {2'b00, 1'b1, 1'b0, 1'b1, 5'b00000, 6'b000000};
            4'd7:    ctrl_of = {9'b000000000, 1'b1, 2'b00, 2'b10, 2'b00};
            4'd8:    ctrl_of = {7'b0000000, 1'b1, 1'b1, 1'b0, 6'b000000};
            4'd9:    ctrl_of = {1'b0, 1'b1, 7'b0000000, 1'b1, 2'b00, 2'b01, 2'b01};
            4'd10:   ctrl_of = {1'b1, 9'b000000000, 2'b00, 2'b00, 2'b10};
            4'd11:   ctrl_of = {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00};
            4'd12:   ctrl_of = {8'b00000000, 1'b1, 1'b0, 6'b000000};
            default: ctrl_of = 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] st, input logic rdy);
        exp_t e;
        e.st   = st;
        e.ctrl = ctrl_of(st, rdy);
        e.hlt  = (st == 4'd13);
        e.ill  = exp_ill;
        e.tmo  = exp_to;
        e.cnt  = exp_cnt;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_dut();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "state", 32'(state), 32'(e.st));
        chk(t, "ctrl", 32'(obs_ctrl), 32'(e.ctrl));
        chk(t, "halted", 32'(halted), 32'(e.hlt));
        chk(t, "illegal_op", 32'(illegal_op), 32'(e.ill));
        chk(t, "mem_timeout", 32'(mem_timeout), 32'(e.tmo));
        chk(t, "instr_count", 32'(instr_count), 32'(e.cnt));
        $display("cycle %-12s state=%0d ctrl=%04h halted=%0d ill=%0d tmo=%0d cnt=%0d",
                 t, state, obs_ctrl, halted, illegal_op, mem_timeout, instr_count);
    endtask

    // Called at posedge+1; checks the cycle whose state is st, returns at next posedge+1.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st);
        opcode    = op;
        mem_ready = rdy;
        push_exp(tag, st, rdy);
        @(negedge clk);
        check_dut();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 4'd0, mem_ready);
        check_dut();
        rst = 1'b1;
    endtask

    initial begin
        // R-type: 0,1,2,7,8,1
        do_reset();
        cyc("idle", OP_R, 1'b1, 4'd0);
        cyc("r_fetch", OP_R, 1'b1, 4'd1);
        cyc("r_decode", OP_R, 1'b1, 4'd2);
        cyc("r_exec", OP_R, 1'b1, 4'd7);
        cyc("r_rwb", OP_R, 1'b1, 4'd8);
        exp_cnt++;
        // lw with three wait states in MEMRD, then ready on the boundary cycle
        cyc("lw_fetch", OP_LW, 1'b1, 4'd1);
        cyc("lw_decode", OP_LW, 1'b1, 4'd2);
        cyc("lw_addr", OP_LW, 1'b1, 4'd3);
        for (int i = 0; i < 3; i++) cyc("lw_wait", OP_LW, 1'b0, 4'd4);
        cyc("lw_rd", OP_LW, 1'b1, 4'd4);
        cyc("lw_wb", OP_LW, 1'b1, 4'd5);
        exp_cnt++;
        // beq with two fetch stalls
        cyc("beq_fstall", OP_BEQ, 1'b0, 4'd1);
        cyc("beq_fstall", OP_BEQ, 1'b0, 4'd1);
        cyc("beq_fetch", OP_BEQ, 1'b1, 4'd1);
        cyc("beq_decode", OP_BEQ, 1'b1, 4'd2);
        cyc("beq_branch", OP_BEQ, 1'b1, 4'd9);
        exp_cnt++;
        // sw zero wait
        cyc("sw_fetch", OP_SW, 1'b1, 4'd1);
        cyc("sw_decode", OP_SW, 1'b1, 4'd2);
        cyc("sw_addr", OP_SW, 1'b1, 4'd3);
        cyc("sw_wr", OP_SW, 1'b1, 4'd6);
        exp_cnt++;
        // addi
        cyc("addi_fetch", OP_ADDI, 1'b1, 4'd1);
        cyc("addi_decode", OP_ADDI, 1'b1, 4'd2);
        cyc("addi_ex", OP_ADDI, 1'b1, 4'd11);
        cyc("addi_wb", OP_ADDI, 1'b1, 4'd12);
        exp_cnt++;
        // jumps until the counter wraps past 2^CNT_W
        for (int i = 0; i < 11; i++) begin
            cyc("j_fetch", OP_J, 1'b1, 4'd1);
            cyc("j_decode", OP_J, 1'b1, 4'd2);
            cyc("j_jump", OP_J, 1'b1, 4'd10);
            exp_cnt++;
        end
        // sw timeout after MAX_WAIT waiting cycles
        cyc("to_fetch", OP_SW, 1'b1, 4'd1);
        cyc("to_decode", OP_SW, 1'b1, 4'd2);
        cyc("to_addr", OP_SW, 1'b1, 4'd3);
        for (int i = 0; i < MAX_WAIT; i++) cyc("to_wait", OP_SW, 1'b0, 4'd6);
        exp_to = 1'b1;
        cyc("to_halt", OP_SW, 1'b0, 4'd13);
        cyc("to_halt", OP_SW, 1'b1, 4'd13);
        cyc("to_halt", OP_SW, 1'b0, 4'd13);
        // illegal opcode
        do_reset();
        cyc("il_idle", OP_J, 1'b1, 4'd0);
        cyc("il_fetch", OP_J, 1'b1, 4'd1);
        cyc("il_decode", OP_J, 1'b1, 4'd2);
        cyc("il_jump", OP_J, 1'b1, 4'd10);
        exp_cnt++;
        cyc("il_fetch", OP_BAD, 1'b1, 4'd1);
        cyc("il_decode", OP_BAD, 1'b1, 4'd2);
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++)
            cyc("il_halt", OP_BAD, 1'($urandom_range(0, 1)), 4'd13);
        // async reset in the middle of a stalled MEMWR
        do_reset();
        cyc("ar_idle", OP_J, 1'b1, 4'd0);
        cyc("ar_fetch", OP_J, 1'b1, 4'd1);
        cyc("ar_decode", OP_J, 1'b1, 4'd2);
        cyc("ar_jump", OP_J, 1'b1, 4'd10);
        exp_cnt++;
        cyc("ar_fetch", OP_SW, 1'b1, 4'd1);
        cyc("ar_decode", OP_SW, 1'b1, 4'd2);
        cyc("ar_addr", OP_SW, 1'b1, 4'd3);
        cyc("ar_wait", OP_SW, 1'b0, 4'd6);
        #2;
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        push_exp("ar_async", 4'd0, 1'b0);
        check_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("ar_idle2", OP_SW, 1'b0, 4'd0);
        cyc("ar_fetch2", OP_SW, 1'b0, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
